// File: rtl/wb_stage_if.sv
// Writeback stage bundle: W-stage inputs from MEM/WB and the stage's results.
// master drives the W-stage slot, slave is the writeback stage itself.
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             validW;
    logic             multu_enW;
    logic             jr_selW;
    logic [2:0]       super_selW;
    logic             dm2regW;
    logic             jumpW;
    logic             jal_selW;
    logic             we_regW;
    logic [31:0]      pc_plus_4W;
    logic [31:0]      alu_paW;
    logic [63:0]      alu_outW;
    logic [31:0]      rd_dmW;
    logic [31:0]      shiftyW;
    logic [31:0]      jtaW;
    logic [4:0]       rf_waW;
    logic [31:0]      wd_rf;
    logic [4:0]       wa_rf;
    logic             we_rf;
    logic [31:0]      HI_q;
    logic [31:0]      LO_q;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             byp_valid;
    logic [4:0]       byp_wa;
    logic [31:0]      byp_wd;
    logic [CNT_W-1:0] retired;

    modport master (
        output validW, multu_enW, jr_selW, super_selW, dm2regW,
        output jumpW, jal_selW, we_regW, pc_plus_4W, alu_paW,
        output alu_outW, rd_dmW, shiftyW, jtaW, rf_waW,
        input  wd_rf, wa_rf, we_rf, HI_q, LO_q,
        input  pc_redirect, pc_target,
        input  byp_valid, byp_wa, byp_wd, retired
    );

    modport slave (
        input  validW, multu_enW, jr_selW, super_selW, dm2regW,
        input  jumpW, jal_selW, we_regW, pc_plus_4W, alu_paW,
        input  alu_outW, rd_dmW, shiftyW, jtaW, rf_waW,
        output wd_rf, wa_rf, we_rf, HI_q, LO_q,
        output pc_redirect, pc_target,
        output byp_valid, byp_wa, byp_wd, retired
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: result select, RF write port, HI/LO, late
// jump redirect, registered bypass copy and retired-instruction counter.
module wb_stage #(
    parameter int RA_REG = 31,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res;
    logic [31:0]      wd;
    logic [4:0]       wa;
    logic             we;
    logic             byp_v_q;
    logic [4:0]       byp_wa_q;
    logic [31:0]      byp_wd_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        res = '0;
        unique case (bus.super_selW)
            3'b000:  res = bus.dm2regW ? bus.rd_dmW : bus.alu_outW[31:0];
            3'b001:  res = hi_q;
            3'b010:  res = lo_q;
            3'b011:  res = bus.shiftyW;
            3'b100:  res = bus.pc_plus_4W;
            default: res = '0;
        endcase
    end

    // jal overrides both data and address; $0 is never written
    assign wd = bus.jal_selW ? bus.pc_plus_4W : res;
    assign wa = bus.jal_selW ? 5'(RA_REG) : bus.rf_waW;
    assign we = bus.validW & (bus.we_regW | bus.jal_selW) & (wa != 5'd0);

    assign bus.wd_rf = wd;
    assign bus.wa_rf = wa;
    assign bus.we_rf = we;

    assign bus.pc_redirect = bus.validW & (bus.jumpW | bus.jr_selW);
    assign bus.pc_target   = bus.jr_selW ? bus.alu_paW : bus.jtaW;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            byp_v_q  <= 1'b0;
            byp_wa_q <= '0;
            byp_wd_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (bus.validW && bus.multu_enW) begin
                hi_q <= bus.alu_outW[63:32];
                lo_q <= bus.alu_outW[31:0];
            end
            byp_v_q  <= we;
            byp_wa_q <= wa;
            byp_wd_q <= wd;
            if (bus.validW)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.HI_q      = hi_q;
    assign bus.LO_q      = lo_q;
    assign bus.byp_valid = byp_v_q;
    assign bus.byp_wa    = byp_wa_q;
    assign bus.byp_wd    = byp_wd_q;
    assign bus.retired   = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed table, hand sequences and random
// stimulus checked against a behavioural model of the writeback stage.
module tb_wb_stage;
    localparam int CW = 4;

    typedef struct {
        logic        valid, multu, jr, dm2reg, jump, jal, we, rst;
        logic [2:0]  sel;
        logic [31:0] pc4, pa, rd, sh, jta;
        logic [63:0] alu;
        logic [4:0]  wa;
    } in_t;

    typedef struct {
        in_t         i;
        logic [31:0] e_wd;
        logic [4:0]  e_wa;
        logic        e_we;
        logic        e_red;
        logic [31:0] e_tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total = 0;

    logic [31:0] m_hi, m_lo, m_bwd;
    logic [4:0]  m_bwa;
    logic        m_bv;
    int          m_ret;
    vec_t        vq[$];

    wb_stage_if #(.CNT_W(CW)) bus();

    wb_stage #(.RA_REG(31), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", n, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic in_t idle();
        in_t x;
        x.valid = 1'b1; x.multu = 1'b0; x.jr = 1'b0; x.dm2reg = 1'b0;
        x.jump = 1'b0; x.jal = 1'b0; x.we = 1'b0; x.rst = 1'b0;
        x.sel = 3'b000; x.pc4 = 32'h0; x.pa = 32'h0; x.rd = 32'h0;
        x.sh = 32'h0; x.jta = 32'h0; x.alu = 64'h0; x.wa = 5'd0;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.valid = ($urandom_range(0, 4) != 0);
        x.multu = ($urandom_range(0, 3) == 0);
        x.jr = ($urandom_range(0, 5) == 0);
        x.jump = ($urandom_range(0, 5) == 0);
        x.jal = ($urandom_range(0, 6) == 0);
        x.dm2reg = 1'($urandom);
        x.we = 1'($urandom);
        x.rst = ($urandom_range(0, 49) == 0);
        x.sel = 3'($urandom_range(0, 7));
        x.pc4 = $urandom; x.pa = $urandom; x.rd = $urandom;
        x.sh = $urandom; x.jta = $urandom;
        x.alu = {$urandom, $urandom};
        x.wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return x;
    endfunction

    // What the stage should present for a W-slot, from the ISA-level rules
    task automatic ref_out(input in_t x, output logic [31:0] wd,
                           output logic [4:0] wa, output logic we,
                           output logic red, output logic [31:0] tgt);
        logic [31:0] r;
        if (x.sel == 3'd0) r = x.dm2reg ? x.rd : x.alu[31:0];
        else if (x.sel == 3'd1) r = m_hi;
        else if (x.sel == 3'd2) r = m_lo;
        else if (x.sel == 3'd3) r = x.sh;
        else if (x.sel == 3'd4) r = x.pc4;
        else r = 32'h0;
        wd = x.jal ? x.pc4 : r;
        wa = x.jal ? 5'd31 : x.wa;
        we = x.valid && (x.we || x.jal) && (wa != 0);
        red = x.valid && (x.jump || x.jr);
        tgt = x.jr ? x.pa : x.jta;
    endtask

    task automatic drive(input in_t x);
        rst = x.rst;
        bus.validW = x.valid; bus.multu_enW = x.multu;
        bus.jr_selW = x.jr; bus.super_selW = x.sel;
        bus.dm2regW = x.dm2reg; bus.jumpW = x.jump;
        bus.jal_selW = x.jal; bus.we_regW = x.we;
        bus.pc_plus_4W = x.pc4; bus.alu_paW = x.pa;
        bus.alu_outW = x.alu; bus.rd_dmW = x.rd;
        bus.shiftyW = x.sh; bus.jtaW = x.jta; bus.rf_waW = x.wa;
        #1;
    endtask

    task automatic chk_comb_model(input in_t x);
        logic [31:0] wd, tgt;
        logic [4:0]  wa;
        logic        we, red;
        ref_out(x, wd, wa, we, red, tgt);
        chk("wd_rf", 64'(bus.wd_rf), 64'(wd));
        chk("wa_rf", 64'(bus.wa_rf), 64'(wa));
        chk("we_rf", 64'(bus.we_rf), 64'(we));
        chk("pc_redirect", 64'(bus.pc_redirect), 64'(red));
        if (red)
            chk("pc_target", 64'(bus.pc_target), 64'(tgt));
    endtask

    task automatic chk_regs();
        chk("HI_q", 64'(bus.HI_q), 64'(m_hi));
        chk("LO_q", 64'(bus.LO_q), 64'(m_lo));
        chk("byp_valid", 64'(bus.byp_valid), 64'(m_bv));
        if (m_bv) begin
            chk("byp_wa", 64'(bus.byp_wa), 64'(m_bwa));
            chk("byp_wd", 64'(bus.byp_wd), 64'(m_bwd));
        end
        chk("retired", 64'(bus.retired), 64'(m_ret));
    endtask

    // Advance model and DUT one edge with the currently driven slot x
    task automatic tick(input in_t x);
        logic [31:0] wd, tgt;
        logic [4:0]  wa;
        logic        we, red;
        ref_out(x, wd, wa, we, red, tgt);
        if (x.rst) begin
            m_hi = 0; m_lo = 0; m_bv = 0; m_bwa = 0; m_bwd = 0; m_ret = 0;
        end else begin
            if (x.valid && x.multu) begin
                m_hi = x.alu[63:32];
                m_lo = x.alu[31:0];
            end
            m_bv = we; m_bwa = wa; m_bwd = wd;
            if (x.valid) m_ret = (m_ret + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic add(input in_t x, input logic [31:0] wd,
                       input logic [4:0] wa, input logic we,
                       input logic red, input logic [31:0] tgt);
        vec_t v;
        v.i = x; v.e_wd = wd; v.e_wa = wa; v.e_we = we;
        v.e_red = red; v.e_tgt = tgt;
        vq.push_back(v);
    endtask

    initial begin
        in_t b;
        int  ret0;
        logic [31:0] hi0, lo0;

        // reset with a concurrent multu that must be lost
        m_hi = 32'hx; m_lo = 32'hx; m_bv = 1'bx; m_bwa = 'x; m_bwd = 'x;
        m_ret = 0;
        b = idle(); b.rst = 1; b.multu = 1; b.alu = 64'hDEAD_BEEF_0000_0001;
        drive(b);
        @(posedge clk); #1;
        tick(b);
        chk("rst_HI", 64'(bus.HI_q), 64'h0);
        chk("rst_LO", 64'(bus.LO_q), 64'h0);
        chk("rst_retired", 64'(bus.retired), 64'h0);
        chk("rst_byp_valid", 64'(bus.byp_valid), 64'h0);

        // directed table
        b = idle(); b.dm2reg = 1; b.rd = 32'h1234; b.wa = 5; b.we = 1;
        b.alu = 64'h5555;
        add(b, 32'h1234, 5, 1, 0, 0);
        b.wa = 0;
        add(b, 32'h1234, 0, 0, 0, 0);
        b = idle(); b.alu = 64'h7_0000_ABCD; b.wa = 9; b.we = 1;
        add(b, 32'hABCD, 9, 1, 0, 0);
        b = idle(); b.sel = 3; b.sh = 32'hF00F; b.wa = 10; b.we = 1;
        add(b, 32'hF00F, 10, 1, 0, 0);
        b = idle(); b.sel = 4; b.pc4 = 32'h44; b.wa = 11; b.we = 1;
        add(b, 32'h44, 11, 1, 0, 0);
        b = idle(); b.sel = 6; b.sh = 32'h1; b.wa = 12; b.we = 1;
        add(b, 32'h0, 12, 1, 0, 0);
        b = idle(); b.jal = 1; b.jump = 1; b.pc4 = 32'h0040_0008;
        b.jta = 32'h0040_0100; b.wa = 3;
        add(b, 32'h0040_0008, 31, 1, 1, 32'h0040_0100);
        b = idle(); b.jr = 1; b.jump = 1; b.pa = 32'h0040_0020;
        b.jta = 32'h0040_0100;
        add(b, 32'h0, 0, 0, 1, 32'h0040_0020);
        b = idle(); b.jump = 1; b.jta = 32'h0040_0200;
        add(b, 32'h0, 0, 0, 1, 32'h0040_0200);

        foreach (vq[k]) begin
            drive(vq[k].i);
            chk($sformatf("tab%0d_wd", k), 64'(bus.wd_rf), 64'(vq[k].e_wd));
            chk($sformatf("tab%0d_wa", k), 64'(bus.wa_rf), 64'(vq[k].e_wa));
            chk($sformatf("tab%0d_we", k), 64'(bus.we_rf), 64'(vq[k].e_we));
            chk($sformatf("tab%0d_red", k), 64'(bus.pc_redirect),
                64'(vq[k].e_red));
            if (vq[k].e_red)
                chk($sformatf("tab%0d_tgt", k), 64'(bus.pc_target),
                    64'(vq[k].e_tgt));
            tick(vq[k].i);
        end

        // multu then mfhi / mflo
        b = idle(); b.multu = 1; b.alu = 64'h0000_0002_8000_0000;
        drive(b); tick(b);
        b = idle(); b.sel = 1; b.we = 1; b.wa = 8;
        drive(b);
        chk("mfhi_wd", 64'(bus.wd_rf), 64'h2);
        chk("mfhi_we", 64'(bus.we_rf), 64'h1);
        tick(b);
        chk("mfhi_byp_wd", 64'(bus.byp_wd), 64'h2);
        b.sel = 2;
        drive(b);
        chk("mflo_wd", 64'(bus.wd_rf), 64'h8000_0000);
        tick(b);
        chk("mflo_byp_wd", 64'(bus.byp_wd), 64'h8000_0000);

        // bubble: no redirect, no write, no count, no HI/LO update
        ret0 = m_ret; hi0 = m_hi; lo0 = m_lo;
        b = idle(); b.valid = 0; b.jr = 1; b.jump = 1; b.multu = 1;
        b.pa = 32'h0040_0020; b.alu = 64'h1111_2222_3333_4444;
        b.we = 1; b.wa = 7;
        drive(b);
        chk("bub_red", 64'(bus.pc_redirect), 64'h0);
        chk("bub_we", 64'(bus.we_rf), 64'h0);
        tick(b);
        chk("bub_retired", 64'(bus.retired), 64'(ret0));
        chk("bub_HI", 64'(bus.HI_q), 64'(hi0));
        chk("bub_LO", 64'(bus.LO_q), 64'(lo0));
        chk("bub_byp_valid", 64'(bus.byp_valid), 64'h0);

        // counter wrap with a 4-bit counter
        b = idle(); b.rst = 1;
        drive(b); tick(b);
        b = idle();
        drive(b);
        for (int i = 0; i < 17; i++) tick(b);
        chk("wrap_retired", 64'(bus.retired), 64'h1);
        b.valid = 0;
        drive(b);
        for (int i = 0; i < 3; i++) tick(b);
        chk("wrap_bubbles", 64'(bus.retired), 64'h1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            b = rnd();
            drive(b);
            chk_comb_model(b);
            tick(b);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline. Consumes the W-stage outputs of the MEM/WB pipeline register.
- Selects the register-file write data and write address, and enforces the write enable.
- Owns the architectural HI/LO registers that multu updates, and exports them back to EX.
- Produces the late jump/jr PC redirect, a one-cycle-delayed writeback bypass copy, and a retired-instruction counter.

Parameters:
RA_REG, 31, register index written by jal
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
validW  in  1  W-stage slot holds a real instruction (0 = bubble)
multu_enW  in  1  write HI/LO from alu_outW
jr_selW  in  1  jr: redirect to alu_paW
super_selW  in  3  result source select
dm2regW  in  1  take rd_dmW instead of ALU low word (when super_selW=000)
jumpW  in  1  j/jal: redirect to jtaW
jal_selW  in  1  force write addr RA_REG, data pc_plus_4W
we_regW  in  1  register write requested
pc_plus_4W  in  32  return address
alu_paW  in  32  jr target (rs value)
alu_outW  in  64  ALU result; [63:32] HI, [31:0] LO/result
rd_dmW  in  32  load data
shiftyW  in  32  shifter result
jtaW  in  32  jump target
rf_waW  in  5  destination register
wd_rf  out  32  register-file write data (comb)
wa_rf  out  5  register-file write address (comb)
we_rf  out  1  register-file write enable (comb)
HI_q  out  32  HI register
LO_q  out  32  LO register
pc_redirect  out  1  take pc_target next cycle (comb)
pc_target  out  32  redirect target (comb)
byp_valid  out  1  registered: last cycle's write valid
byp_wa  out  5  registered write address
byp_wd  out  32  registered write data
retired  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset is synchronous on the clk edge with rst=1. It clears HI_q, LO_q, byp_valid, byp_wa, byp_wd and retired to 0.
- Result mux by super_selW:
  - 000: rd_dmW if dm2regW, else alu_outW[31:0]
  - 001: HI_q
  - 010: LO_q
  - 011: shiftyW
  - 100: pc_plus_4W
  - 101–111: 0
- jal_selW=1 overrides the mux: wd_rf=pc_plus_4W and wa_rf=RA_REG. Otherwise wa_rf=rf_waW.
- we_rf = validW & (we_regW | jal_selW) & (wa_rf != 0). A write to $0 is always suppressed.
- HI/LO update: on a clk edge with validW & multu_enW, HI_q<=alu_outW[63:32] and LO_q<=alu_outW[31:0]. Otherwise they hold.
- mfhi/mflo in W reads the current registered HI_q/LO_q. The result of a multu in W this cycle is visible to mfhi/mflo starting next cycle.
- pc_redirect = validW & (jumpW | jr_selW). pc_target = alu_paW if jr_selW, else jtaW.
  - If jr_selW and jumpW are both set, jr wins.
  - With validW=0, pc_redirect=0 and pc_target is don't-care.
- Bypass registers update every clk edge: byp_valid<=we_rf, byp_wa<=wa_rf, byp_wd<=wd_rf. A bubble therefore yields byp_valid=0 next cycle.
- retired increments by 1 on each edge with validW=1 and rst=0. It wraps modulo 2^CNT_W.
- Reset has priority over all updates in the same edge, including a concurrent multu. A multu in W during reset is lost.
- Latency:
  - wd_rf, wa_rf, we_rf, pc_redirect and pc_target are combinational, 0 cycles.
  - HI/LO, the bypass registers and retired update 1 cycle after the edge.

Test Plan:
1. Reset: assert rst 1 cycle with multu_enW=1, validW=1, alu_outW=64'hDEAD_BEEF_0000_0001 -> HI_q=LO_q=0, retired=0, byp_valid=0.
2. multu then mfhi/mflo:
   - Cycle N: multu_enW=1, alu_outW=64'h0000_0002_8000_0000.
   - Cycle N+1: super_selW=001, we_regW=1, rf_waW=8 -> wd_rf=32'h2, we_rf=1.
   - Cycle N+2: super_selW=010 -> wd_rf=32'h8000_0000.
   - byp_wd on those cycles follows one cycle later.
3. Load vs ALU, plus $0 suppression:
   - super_selW=000, dm2regW=1, rd_dmW=32'h1234, rf_waW=5 -> wd_rf=32'h1234, we_rf=1.
   - Same with rf_waW=0 -> we_rf=0.
4. jal: jal_selW=1, jumpW=1, pc_plus_4W=32'h0040_0008, jtaW=32'h0040_0100, rf_waW=3 -> wa_rf=31, wd_rf=32'h0040_0008, we_rf=1, pc_redirect=1, pc_target=32'h0040_0100.
5. jr priority and bubble:
   - jr_selW=1, jumpW=1, alu_paW=32'h0040_0020 -> pc_target=32'h0040_0020.
   - Same inputs with validW=0 -> pc_redirect=0, we_rf=0, retired unchanged, HI/LO unchanged even with multu_enW=1.
6. Counter wrap: with CNT_W=4, run 17 valid cycles from reset -> retired=1. Insert 3 bubbles -> retired still 1.
